// File: rtl/mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// mul_share_arbiter
//
// Shares one combinational 4x4 multiplier between two requesters. A
// round-robin arbiter picks a requester in IDLE, latches its operands, holds
// them on the multiplier for WAIT_CYCLES settle cycles, then registers the
// 8-bit product and pulses the owner's done line for one cycle.
//
// Handshake: a requester raises req with stable operands and keeps them until
// it sees its gnt pulse (one cycle, the cycle after the sampling edge).
// Operands are don't-care after that edge. done pulses for one cycle when
// p_out holds that requester's product; p_out then holds until the next done.
// A req still high in the cycle after done is a new request.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   req0/a0/b0     requester 0 request level and operands
//   req1/a1/b1     requester 1 request level and operands
//   gnt0/gnt1      one-cycle grant pulses (operands accepted)
//   done0/done1    one-cycle result pulses (p_out valid for owner)
//   p_out          last registered product
//   busy           high while a job is in the MUL state
//
// WAIT_CYCLES: settle cycles from grant edge to capture edge, legal 1..15.
// -----------------------------------------------------------------------------

module Multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'd0, a} * {4'd0, b};
endmodule

module mul_share_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] p_out,
  output logic       busy
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic [7:0] p_q, p_d;
  logic       busy_q, busy_d;

  logic [7:0] mul_p;
  logic       win;

  // Latched operands drive the shared multiplier for the whole MUL state.
  Multiplier_4bit u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    p_d     = p_q;
    busy_d  = busy_q;
    win     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins; last resets to 1
          // so requester 0 takes the first tie.
          if (req0 && req1) win = ~last_q;
          else              win = req1;
          op_a_d  = win ? a1 : a0;
          op_b_d  = win ? b1 : b0;
          owner_d = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          p_d     = mul_p;
          done0_d = ~owner_q;
          done1_d = owner_q;
          last_d  = owner_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= 4'd0;
      op_b_q  <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      p_q     <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign p_out = p_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mul_share_arbiter
//
// Directed bench for mul_share_arbiter with WAIT_CYCLES=2. Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------

module tb_mul_share_arbiter;

  localparam int WAIT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] p_out;

  int n_cmp = 0;
  int n_err = 0;

  mul_share_arbiter #(.WAIT_CYCLES(WAIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .p_out (p_out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and check that pulses are mutually exclusive.
  task automatic step();
    @(posedge clk);
    #1;
    check("onehot_pulses", 32'($onehot0({gnt0, gnt1, done0, done1})), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt0"},  32'(gnt0),  32'd0);
    check({tag, "_gnt1"},  32'(gnt1),  32'd0);
    check({tag, "_done0"}, 32'(done0), 32'd0);
    check({tag, "_done1"}, 32'(done1), 32'd0);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_p_out"}, 32'(p_out), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Single-requester job: wait for grant, drop req, wait for done, check product.
  task automatic run_job(input logic id, input logic [3:0] a, input logic [3:0] b);
    int waited;
    logic seen;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      seen = id ? gnt1 : gnt0;
    end
    check("job_grant_seen", 32'(seen), 32'd1);
    check("job_other_gnt", 32'(id ? gnt0 : gnt1), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    a0 = 4'hx; b0 = 4'hx; a1 = 4'hx; b1 = 4'hx;
    seen = 1'b0;
    waited = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      waited++;
      seen = id ? done1 : done0;
    end
    check("job_done_seen", 32'(seen), 32'd1);
    check("job_latency", 32'(waited), 32'(WAIT));
    check("job_product", 32'(p_out), 32'(a) * 32'(b));
  endtask

  initial begin
    int exp_id;
    int waited;
    logic seen;

    // Reset held with random inputs toggling.
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      a0 = 4'($urandom_range(0, 15));
      b0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      b1 = 4'($urandom_range(0, 15));
      step();
      check_idle_outputs("in_reset");
    end
    req0 = 1'b0;
    req1 = 1'b0;
    rst = 1'b0;
    step();
    step();
    check_idle_outputs("after_release");

    // Single job 3*5 on requester 0.
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
    step();                                   // edge T
    check("a_gnt0_T", 32'(gnt0), 32'd1);
    check("a_gnt1_T", 32'(gnt1), 32'd0);
    check("a_busy_T", 32'(busy), 32'd1);
    req0 = 1'b0; a0 = 4'd0;
    step();                                   // T+1
    check("a_gnt0_T1", 32'(gnt0), 32'd0);
    check("a_busy_T1", 32'(busy), 32'd1);
    check("a_done0_T1", 32'(done0), 32'd0);
    step();                                   // T+2
    check("a_done0_T2", 32'(done0), 32'd1);
    check("a_done1_T2", 32'(done1), 32'd0);
    check("a_p_T2", 32'(p_out), 32'd15);
    check("a_busy_T2", 32'(busy), 32'd0);
    step();                                   // T+3
    check("a_done0_T3", 32'(done0), 32'd0);
    check("a_p_hold", 32'(p_out), 32'd15);

    // Simultaneous requests after reset: 0 wins first, then 1.
    do_reset();
    req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
    req1 = 1'b1; a1 = 4'd7;  b1 = 4'd9;
    step();                                   // T
    check("tie_gnt0_T", 32'(gnt0), 32'd1);
    check("tie_gnt1_T", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    step();                                   // T+1
    step();                                   // T+2
    check("tie_done0", 32'(done0), 32'd1);
    check("tie_p0", 32'(p_out), 32'd225);
    step();                                   // T+3
    check("tie_gnt1_T3", 32'(gnt1), 32'd1);
    check("tie_p_hold_over_gnt", 32'(p_out), 32'd225);
    req1 = 1'b0;
    step();                                   // T+4
    step();                                   // T+5
    check("tie_done1", 32'(done1), 32'd1);
    check("tie_p1", 32'(p_out), 32'd63);

    // Both held high for 8 jobs: grants must alternate starting with 0.
    step();
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd3;
    req1 = 1'b1; a1 = 4'd4; b1 = 4'd5;
    exp_id = 0;
    for (int job = 0; job < 8; job++) begin
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
        step();
        seen = gnt0 | gnt1;
      end
      check("rr_grant_seen", 32'(seen), 32'd1);
      check("rr_grant_id", 32'(gnt1), 32'(exp_id));
      if (job == 7) begin req0 = 1'b0; req1 = 1'b0; end
      step();
      step();
      check("rr_done_owner", {30'd0, done1, done0}, (exp_id == 1) ? 32'd2 : 32'd1);
      check("rr_product", 32'(p_out), (exp_id == 1) ? 32'd20 : 32'd6);
      exp_id = 1 - exp_id;
    end
    step();
    check("rr_idle_after", 32'(busy), 32'd0);

    // Operands latched at grant: later change on a0 must not matter.
    req0 = 1'b1; a0 = 4'd12; b0 = 4'd10;
    step();
    check("latch_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0; a0 = 4'd0;
    step();
    step();
    check("latch_done0", 32'(done0), 32'd1);
    check("latch_p", 32'(p_out), 32'd120);

    // Reset mid-job aborts it.
    step();
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd9;
    step();                                   // T
    check("abort_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    step();                                   // T+1
    rst = 1'b1;
    #1;
    check_idle_outputs("abort_async");
    step();
    step();
    check_idle_outputs("abort_held");
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | done0 | done1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_p_zero", 32'(p_out), 32'd0);
    run_job(1'b1, 4'd6, 4'd7);

    // Every operand pair through both requesters.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_job(1'b0, 4'(a), 4'(b));
        run_job(1'b1, 4'(b), 4'(a));
      end
    end

    // Short req glitch between edges in IDLE is ignored.
    step();
    #2 req1 = 1'b1;
    #2 req1 = 1'b0;
    waited = 0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | gnt0 | gnt1 | busy;
    end
    check("glitch_ignored", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout simulation did not complete observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one combinational Multiplier_4bit (ports a, b, p) between two requesters.
- Round-robin arbitration; the granted requester's operands are latched and held stable for a fixed number of settle cycles, then the 8-bit product is registered and returned with a one-cycle done pulse.
- Sits between the two client blocks and the multiplier instance, which it instantiates internally.

Parameters:
- WAIT_CYCLES, 2, settle cycles between grant and result capture; legal range 1..15; 4-bit counter.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request, level
- a0  input  4  requester 0 multiplicand
- b0  input  4  requester 0 multiplier
- req1  input  1  requester 1 request, level
- a1  input  4  requester 1 multiplicand
- b1  input  4  requester 1 multiplier
- gnt0  output  1  one-cycle pulse: requester 0 operands accepted
- gnt1  output  1  one-cycle pulse: requester 1 operands accepted
- done0  output  1  one-cycle pulse: p_out valid for requester 0
- done1  output  1  one-cycle pulse: p_out valid for requester 1
- p_out  output  8  last registered product
- busy  output  1  high while in MUL state

Behaviour:
- One clock (clk). rst is asynchronous, active-high. All outputs registered.
- Reset values:
  - state=IDLE, gnt0=gnt1=done0=done1=busy=0, p_out=8'h00.
  - Internal: op_a=op_b=0, owner=0, cnt=0, last=1, so requester 0 wins the first tie.
- States: IDLE, MUL.
- IDLE:
  - No req: stay in IDLE, all pulses 0.
  - Any req sampled at edge T: select the winner, latch its a/b into op_a/op_b, set owner, pulse gnt<owner> during cycle T..T+1, load cnt=WAIT_CYCLES-1, busy=1, go to MUL.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last wins.
- MUL:
  - op_a/op_b drive the multiplier, stable for the whole state.
  - cnt!=0: decrement.
  - cnt==0 at edge: p_out<=p, pulse done<owner> for one cycle, last<=owner, busy<=0, go to IDLE.
- Latency:
  - Grant edge T -> done/p_out edge T+WAIT_CYCLES.
  - Earliest next grant at T+WAIT_CYCLES+1 (one IDLE cycle between jobs).
- Requester rules:
  - Hold req and operands until gnt is seen.
  - Operands are don't-care after the gnt edge.
  - req still high in the cycle after done counts as a new request.
  - Requests arriving during MUL are not lost if held; they are evaluated in IDLE.
- Arithmetic:
  - p_out = op_a*op_b, unsigned, 8 bits, never overflows (max 15*15=225).
  - p_out holds its value between done pulses, including across grants.
- Mutual exclusion: at most one of gnt0/gnt1/done0/done1 is high in any cycle; gnt and done never coincide.
- Reset mid-MUL:
  - Job aborted immediately: no done pulse, p_out=0, last=1.
  - After reset release, pending reqs are re-arbitrated from IDLE.
- A req pulse shorter than one cycle, not sampled high at an edge in IDLE, is ignored.

Test Plan:
- Hold rst=1 with random inputs toggling -> gnt0/1=done0/1=busy=0 and p_out=0 throughout. Release rst -> still idle with no req.
- WAIT_CYCLES=2; req0=1, a0=3, b0=5 sampled at edge T:
  - gnt0=1 for cycle T.
  - busy=1 for T..T+2.
  - done0=1 at T+2 with p_out=15; done1 stays 0.
- After reset, req0 (a0=15, b0=15) and req1 (a1=7, b1=9) both asserted at edge T:
  - gnt0 at T, done0 at T+2 with p_out=225.
  - gnt1 at T+3, done1 at T+5 with p_out=63.
- req0 and req1 held high continuously for 8 jobs -> grants alternate 0,1,0,1,... and no requester is served twice in a row.
- req0 at T with a0=12, b0=10; a0 changed to 0 at T+1 -> done0 at T+2 with p_out=120 (latched operands used).
- rst pulsed during MUL at T+1 -> no done pulse, p_out=0. Then req1 alone -> gnt1 and correct product. Both requesters for all 256 a/b pairs, p_out checked against a*b.
